shift_add_multiply1: RTL and testbench

- Iterative radix-1 unsigned multiplier that retires one multiplier bit per clock using shift-and-add.
- It is the inverse-direction companion to the radix-1 divider step: division uses shift/subtract, this block uses shift/add.
- It sits in the same arithmetic datapath and uses a valid/ready handshake on both its input and its output.

---
 rtl/shift_add_multiply1.sv | 96 +++++++++
 tb/tb_shift_add_multiply1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_add_multiply1.sv
// rtl/shift_add_multiply1.sv - iterative radix-1 unsigned shift-and-add multiplier
// One multiplier bit retired per clock; valid/ready handshake on input and output.
module shift_add_multiply1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       sum;
  logic                 last_iter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // The extra adder bit keeps the carry so the upper half never wraps.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = A;
          prod_d  = {{WIDTH{1'b0}}, B};
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          p_d     = {sum, prod_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // P is a separate register so it stays stable through the next RUN.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign P         = p_q;

endmodule

// File: tb/tb_shift_add_multiply1.sv
// tb/tb_shift_add_multiply1.sv - directed self-checking bench for shift_add_multiply1
// Expected values are hand-computed or formed as a*b in the bench.
module tb_shift_add_multiply1;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_add_multiply1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P        (P),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency/busy, optional stall with ignored pokes, consume.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int gap,
                    input int stall, input bit hold_ready, input bit poke);
    logic [31:0] exp;
    int cyc;
    int nb;
    exp = 32'(a) * 32'(b);
    repeat (gap) tick();
    chk("in_ready_before", 32'(in_ready), 32'd1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = hold_ready;
    tick();
    in_valid = 1'b0;
    A        = 8'($urandom);
    B        = 8'($urandom);
    cyc = 0;
    nb  = 0;
    while (!out_valid && cyc < 20) begin
      if (busy) nb++;
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd8);
    chk("busy_cycles", 32'(nb), 32'd8);
    chk("product", 32'(P), exp);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        A        = 8'd33;
        B        = 8'd44;
      end
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_product", 32'(P), exp);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    if (!hold_ready) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end else begin
      tick();
      out_ready = 1'b0;
    end
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_product_held", 32'(P), exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_P", 32'(P), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic, out_ready held high throughout: 13*11 = 0x008F
    op(8'd13, 8'd11, 0, 0, 1'b1, 1'b0);
    // Max operands: 255*255 = 0xFE01
    op(8'd255, 8'd255, 1, 0, 1'b0, 1'b0);
    // Zero and identity
    op(8'd0, 8'd200, 0, 0, 1'b0, 1'b0);
    op(8'd1, 8'd200, 2, 0, 1'b0, 1'b0);
    // Backpressure with ignored input pulses: 7*9 = 63
    op(8'd7, 8'd9, 0, 5, 1'b0, 1'b1);

    // Reset mid-run during iteration 4 of 100*3
    A        = 8'd100;
    B        = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_P", 32'(P), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    op(8'd5, 8'd6, 0, 0, 1'b0, 1'b0);

    // Back-to-back random operands with random gaps and stalls
    for (int n = 0; n < 1000; n++) begin
      op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
